// File: rtl/lab3_pkg.sv
// Shared types and the Lab3 golden function for the self-test block.
package lab3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int unsigned NUM_VECTORS = 8;

  // Returns {x, y} for input vector {a, b, c}.
  function automatic logic [1:0] lab3_golden(input logic [2:0] abc);
    logic a;
    logic b;
    logic c;
    a = abc[2];
    b = abc[1];
    c = abc[0];
    return {~(c ^ (a | b)), a & b};
  endfunction

endpackage

// File: rtl/lab3_self_test.sv
// Exhaustive sequential tester for the Lab3 circuit: sweeps all 8 vectors, checks x/y, reports.
// Optional macro LAB3_SELF_TEST_STOP_ON_FAIL_EN stops the sweep at the first mismatch.
module lab3_self_test
  import lab3_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drv_c,
  input  logic       dut_x,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [3:0] err_count,
  output logic [2:0] first_fail,
  output logic       first_fail_vld
);

  localparam int unsigned     CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_VECTORS - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             launch;
  logic             mismatch;
  logic             last_vec;

  // done trails entry into DONE by one cycle so results are stable when it rises;
  // a restart from DONE is only accepted once done is visible.
  always_comb begin
    launch     = 1'b0;
    mismatch   = 1'b0;
    last_vec   = (idx == LAST_IDX);
    state_next = state;
    case (state)
      IDLE: begin
        launch = start;
        if (start) state_next = SETTLE;
      end
      SETTLE: begin
        if (cnt == CNT_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        mismatch = ({dut_x, dut_y} != lab3_golden(idx));
`ifdef LAB3_SELF_TEST_STOP_ON_FAIL_EN
        if (mismatch || last_vec) state_next = DONE;
        else                      state_next = SETTLE;
`else
        if (last_vec) state_next = DONE;
        else          state_next = SETTLE;
`endif
      end
      DONE: begin
        launch = start && done;
        if (start && done) state_next = SETTLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      done           <= 1'b0;
      fail_mask      <= '0;
      err_count      <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == DONE) && !launch;
      if (launch) begin
        cnt            <= '0;
        idx            <= '0;
        fail_mask      <= '0;
        err_count      <= '0;
        first_fail     <= '0;
        first_fail_vld <= 1'b0;
      end else begin
        case (state)
          SETTLE: cnt <= cnt + 1'b1;
          SAMPLE: begin
            if (mismatch) begin
              fail_mask[idx] <= 1'b1;
              err_count      <= err_count + 4'd1;
              if (!first_fail_vld) begin
                first_fail     <= idx;
                first_fail_vld <= 1'b1;
              end
            end
            if (state_next == SETTLE) begin
              idx <= idx + 3'd1;
              cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy  = (state != IDLE) && !done;
  assign pass  = done && (fail_mask == '0);
  assign drv_a = idx[2];
  assign drv_b = idx[1];
  assign drv_c = idx[0];

endmodule
